// File: rtl/tage_pkg.sv
// Shared types and helpers for the TAGE base-table (T0) controller.
package tage_pkg;
  localparam int unsigned T0_IDX_MAX = 16;

  typedef logic [1:0] ctr_t;

  typedef enum logic {INIT, RUN} t0_state_e;

  // idx is carried at full width so one entry type fits any table size
  typedef struct packed {
    logic [T0_IDX_MAX-1:0] idx;
    ctr_t                  ctr;
  } uq_entry_t;

  function automatic ctr_t sat_inc(input ctr_t c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [T0_IDX_MAX-1:0] t0_index(input logic [31:0] pc,
                                                     input logic [T0_IDX_MAX-1:0] ghr,
                                                     input int unsigned bits);
    logic [T0_IDX_MAX-1:0] mask;
    mask = T0_IDX_MAX'((32'd1 << bits) - 32'd1);
    return (pc[T0_IDX_MAX+1:2] ^ ghr) & mask;
  endfunction
endpackage

// File: rtl/tage_uq_fifo.sv
// Circular update queue; entries are presented oldest-first so the
// forwarding compare can pick the youngest match by position.
module tage_uq_fifo
  import tage_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  uq_entry_t             push_data_i,
  input  logic                  pop_i,
  output uq_entry_t [DEPTH-1:0] ord_o,
  output logic      [DEPTH-1:0] vld_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int unsigned PW = $clog2(DEPTH);

  uq_entry_t [DEPTH-1:0] mem_q;
  logic [PW-1:0]         head_q, tail_q;
  logic [PW:0]           cnt_q;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ord_o[i] = mem_q[head_q + PW'(i)];
      vld_o[i] = (cnt_q > (PW+1)'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[tail_q] <= push_data_i;
        tail_q        <= tail_q + PW'(1);
      end
      if (pop_i) head_q <= head_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
  end
endmodule

// File: rtl/tage_t0_ctrl.sv
// T0 bimodal table access controller: init sweep, lookup/update
// arbitration on a single-ported SRAM, and queued-update forwarding.
module tage_t0_ctrl
  import tage_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 10,
  parameter int unsigned GHR_BITS   = 2,
  parameter int unsigned UQ_DEPTH   = 4,
  parameter ctr_t        INIT_CTR   = 2'b01
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  lookup_valid_i,
  input  logic [31:0]           lookup_pc_i,
  input  logic [GHR_BITS-1:0]   lookup_ghr_i,
  output logic                  lookup_ready_o,
  output logic                  pred_valid_o,
  output ctr_t                  pred_ctr_o,
  input  logic                  update_valid_i,
  input  logic [31:0]           update_pc_i,
  input  logic [GHR_BITS-1:0]   update_ghr_i,
  input  logic                  update_taken_i,
  input  ctr_t                  update_pred_i,
  output logic                  update_ready_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [INDEX_BITS-1:0] mem_addr_o,
  output ctr_t                  mem_wdata_o,
  input  ctr_t                  mem_rdata_i,
  output logic                  init_done_o
);
  t0_state_e             state_q, state_d;
  logic [INDEX_BITS-1:0] sweep_q, sweep_d;
  logic                  pred_valid_q, fwd_hit_q, fwd_hit_d;
  ctr_t                  fwd_ctr_q, fwd_ctr_d, pred_hold_q;

  uq_entry_t [UQ_DEPTH-1:0] uq_ord;
  logic      [UQ_DEPTH-1:0] uq_vld;
  logic                     uq_full, uq_empty;

  logic [T0_IDX_MAX-1:0] lk_idx, up_idx;
  ctr_t                  up_new;
  uq_entry_t             push_ent;
  logic                  run, lk_acc, up_acc, push, drain;

  assign lk_idx   = t0_index(lookup_pc_i, T0_IDX_MAX'(lookup_ghr_i), INDEX_BITS);
  assign up_idx   = t0_index(update_pc_i, T0_IDX_MAX'(update_ghr_i), INDEX_BITS);
  assign up_new   = update_taken_i ? sat_inc(update_pred_i) : sat_dec(update_pred_i);
  assign push_ent = '{idx: up_idx, ctr: up_new};

  assign run            = (state_q == RUN);
  assign lookup_ready_o = run && !uq_full;
  assign update_ready_o = run && !uq_full;
  assign lk_acc         = lookup_valid_i && lookup_ready_o;
  assign up_acc         = update_valid_i && update_ready_o;
  // Unchanged counters never need a write, so they are accepted and dropped.
  assign push           = up_acc && (up_new != update_pred_i);
  assign drain          = run && !uq_empty && (uq_full || !lookup_valid_i);

  // Qualified with rst_ni so the SRAM sees no activity while reset is held.
  assign mem_en_o    = rst_ni && (!run || lk_acc || drain);
  assign mem_we_o    = rst_ni && (!run || drain);
  assign mem_addr_o  = !mem_en_o ? '0 :
                       !run      ? sweep_q :
                       lk_acc    ? lk_idx[INDEX_BITS-1:0] : uq_ord[0].idx[INDEX_BITS-1:0];
  assign mem_wdata_o = !mem_we_o ? '0 : (!run ? INIT_CTR : uq_ord[0].ctr);

  assign pred_valid_o = pred_valid_q;
  assign pred_ctr_o   = !pred_valid_q ? pred_hold_q : (fwd_hit_q ? fwd_ctr_q : mem_rdata_i);
  assign init_done_o  = run;

  tage_uq_fifo #(.DEPTH(UQ_DEPTH)) u_uq (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i (push_ent),
    .pop_i       (drain),
    .ord_o       (uq_ord),
    .vld_o       (uq_vld),
    .full_o      (uq_full),
    .empty_o     (uq_empty)
  );

  // Later (younger) matches override earlier ones; a same-cycle enqueue is youngest.
  always_comb begin
    fwd_hit_d = 1'b0;
    fwd_ctr_d = '0;
    for (int i = 0; i < UQ_DEPTH; i++) begin
      if (uq_vld[i] && (uq_ord[i].idx == lk_idx)) begin
        fwd_hit_d = 1'b1;
        fwd_ctr_d = uq_ord[i].ctr;
      end
    end
    if (push && (up_idx == lk_idx)) begin
      fwd_hit_d = 1'b1;
      fwd_ctr_d = up_new;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == INIT) begin
      sweep_d = sweep_q + INDEX_BITS'(1);
      if (sweep_q == '1) state_d = RUN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= INIT;
      sweep_q      <= '0;
      pred_valid_q <= 1'b0;
      fwd_hit_q    <= 1'b0;
      fwd_ctr_q    <= '0;
      pred_hold_q  <= '0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      pred_valid_q <= lk_acc;
      fwd_hit_q    <= lk_acc && fwd_hit_d;
      if (lk_acc) fwd_ctr_q <= fwd_ctr_d;
      if (pred_valid_q) pred_hold_q <= pred_ctr_o;
    end
  end
endmodule

// File: tb/tb_tage_t0_ctrl.sv
// Scoreboard bench for tage_t0_ctrl with a behavioral single-port SRAM.
module tb_tage_t0_ctrl;
  localparam int unsigned IB = 4;
  localparam int unsigned GB = 2;
  localparam int unsigned QD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lookup_valid = 1'b0;
  logic [31:0]   lookup_pc = '0;
  logic [GB-1:0] lookup_ghr = '0;
  logic          lookup_ready, pred_valid;
  logic [1:0]    pred_ctr;
  logic          update_valid = 1'b0;
  logic [31:0]   update_pc = '0;
  logic [GB-1:0] update_ghr = '0;
  logic          update_taken = 1'b0;
  logic [1:0]    update_pred = '0;
  logic          update_ready, mem_en, mem_we, init_done;
  logic [IB-1:0] mem_addr;
  logic [1:0]    mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  tage_t0_ctrl #(.INDEX_BITS(IB), .GHR_BITS(GB), .UQ_DEPTH(QD), .INIT_CTR(2'b01)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lookup_valid_i(lookup_valid), .lookup_pc_i(lookup_pc), .lookup_ghr_i(lookup_ghr),
    .lookup_ready_o(lookup_ready), .pred_valid_o(pred_valid), .pred_ctr_o(pred_ctr),
    .update_valid_i(update_valid), .update_pc_i(update_pc), .update_ghr_i(update_ghr),
    .update_taken_i(update_taken), .update_pred_i(update_pred), .update_ready_o(update_ready),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .init_done_o(init_done)
  );

  logic [1:0] sram [16];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Architectural view of the table: updated the moment an update is accepted.
  logic [1:0] ref_tbl [16];
  logic [1:0] exp_pred_q [$];
  logic [5:0] exp_wr_q [$];
  int         sweep_exp = 0;
  int         stall_cnt = 0;
  bit         done_prev = 1'b0;
  logic [1:0] last_pred = '0;
  logic [1:0] nv;
  logic [3:0] ui, li;

  function automatic logic [3:0] idx_of(input logic [31:0] pc, input logic [1:0] ghr);
    return pc[5:2] ^ {2'b00, ghr};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pred_q.delete();
      exp_wr_q.delete();
      sweep_exp = 0;
      done_prev = 1'b0;
      last_pred = '0;
      for (int i = 0; i < 16; i++) ref_tbl[i] = 2'b01;
    end else begin
      if (pred_valid) begin
        chk("pred_expected", 32'(exp_pred_q.size() != 0), 1);
        if (exp_pred_q.size() != 0) chk("pred_ctr", 32'(pred_ctr), 32'(exp_pred_q.pop_front()));
        last_pred = pred_ctr;
      end else begin
        chk("pred_hold", 32'(pred_ctr), 32'(last_pred));
      end
      if (!init_done) begin
        chk("init_ready", 32'({lookup_ready, update_ready}), 0);
        if (mem_en) begin
          chk("init_addr", 32'(mem_addr), 32'(sweep_exp[3:0]));
          chk("init_we", 32'(mem_we), 1);
          chk("init_wdata", 32'(mem_wdata), 1);
          sweep_exp++;
        end
      end else begin
        if (!done_prev) chk("init_len", 32'(sweep_exp), 16);
        if (lookup_valid && !lookup_ready) stall_cnt++;
        if (mem_en && mem_we) begin
          chk("wr_expected", 32'(exp_wr_q.size() != 0), 1);
          if (exp_wr_q.size() != 0) chk("wr", 32'({mem_addr, mem_wdata}), 32'(exp_wr_q.pop_front()));
        end
        if (update_valid && update_ready) begin
          ui = idx_of(update_pc, update_ghr);
          if (update_taken) nv = (update_pred == 2'b11) ? 2'b11 : update_pred + 2'b01;
          else              nv = (update_pred == 2'b00) ? 2'b00 : update_pred - 2'b01;
          if (nv != update_pred) begin
            ref_tbl[ui] = nv;
            exp_wr_q.push_back({ui, nv});
          end
        end
        if (lookup_valid && lookup_ready) begin
          li = idx_of(lookup_pc, lookup_ghr);
          chk("lk_read", 32'({mem_en, mem_we, mem_addr}), 32'({2'b10, li}));
          exp_pred_q.push_back(ref_tbl[li]);
        end
      end
      done_prev = init_done;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_reset_outs();
    chk("rst_ctl", 32'({lookup_ready, pred_valid, update_ready, mem_en, mem_we, init_done}), 0);
    chk("rst_data", 32'({pred_ctr, mem_addr, mem_wdata}), 0);
  endtask

  task automatic wait_init();
    int k = 0;
    while (!init_done && k < 100) begin cyc(); k++; end
    chk("init_timeout", 32'(init_done), 1);
  endtask

  task automatic send_lookup(input logic [31:0] pc, input logic [1:0] ghr);
    bit acc = 1'b0;
    int k = 0;
    lookup_valid = 1'b1; lookup_pc = pc; lookup_ghr = ghr;
    do begin
      @(negedge clk); acc = lookup_ready;
      @(posedge clk); #1; k++;
    end while (!acc && k < 50);
    chk("lk_timeout", 32'(acc), 1);
    lookup_valid = 1'b0;
  endtask

  task automatic send_upd(input logic [31:0] pc, input logic [1:0] ghr,
                          input logic tk, input logic [1:0] pr);
    bit acc = 1'b0;
    int k = 0;
    update_valid = 1'b1; update_pc = pc; update_ghr = ghr;
    update_taken = tk; update_pred = pr;
    do begin
      @(negedge clk); acc = update_ready;
      @(posedge clk); #1; k++;
    end while (!acc && k < 50);
    chk("upd_timeout", 32'(acc), 1);
    update_valid = 1'b0;
  endtask

  logic [3:0] lk_seq [4];

  initial begin
    lk_seq[0] = 4'd1; lk_seq[1] = 4'd2; lk_seq[2] = 4'd3; lk_seq[3] = 4'd6;
    cyc(3);
    @(negedge clk); chk_reset_outs();
    @(posedge clk); #1; rst_n = 1'b1;
    wait_init();

    send_lookup(32'h14, 2'b11);
    send_lookup(32'h14, 2'b00);
    cyc(2);

    send_upd(32'h14, 2'b11, 1'b1, 2'b01);
    cyc(3);
    send_lookup(32'h14, 2'b11);
    cyc(2);

    send_upd(32'h20, 2'b00, 1'b1, 2'b11);
    send_upd(32'h24, 2'b00, 1'b0, 2'b00);
    cyc(4);

    stall_cnt = 0;
    fork
      begin
        lookup_valid = 1'b1; lookup_ghr = '0;
        for (int c = 0; c < 16; c++) begin
          lookup_pc = {26'd0, lk_seq[c % 4], 2'b00};
          cyc();
        end
        lookup_valid = 1'b0;
      end
      begin
        cyc();
        send_upd(32'h04, 2'b00, 1'b1, 2'b01);
        send_upd(32'h08, 2'b00, 1'b0, 2'b01);
        send_upd(32'h0C, 2'b00, 1'b1, 2'b10);
        send_upd(32'h18, 2'b00, 1'b1, 2'b10);
      end
    join
    cyc(6);
    chk("full_stall", 32'(stall_cnt), 1);
    send_lookup(32'h18, 2'b00);
    cyc(2);

    lookup_valid = 1'b1; lookup_pc = 32'h0; lookup_ghr = '0;
    send_upd(32'h1C, 2'b00, 1'b1, 2'b01);
    send_upd(32'h20, 2'b00, 1'b1, 2'b01);
    send_upd(32'h24, 2'b00, 1'b1, 2'b01);
    rst_n = 1'b0;
    lookup_valid = 1'b0;
    @(negedge clk); chk_reset_outs();
    cyc(2);
    @(negedge clk); chk_reset_outs();
    @(posedge clk); #1; rst_n = 1'b1;
    wait_init();
    cyc(10);
    send_lookup(32'h1C, 2'b00);
    cyc(3);

    chk("wr_pending", 32'(exp_wr_q.size()), 0);
    chk("pred_pending", 32'(exp_pred_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
